// File: rtl/mpu_iic_slave.sv
// mpu_iic_slave: I2C target modelling the MPU-6050 register interface
//   clk, rst_n        system clock (>= 16x SCL), synchronous active-low reset
//   scl, sda          I2C bus; sda is open-drain and only ever driven to 0 or Z
//   upd_we/addr/data  host-side write port into the register file
//   wr_strobe/addr/data  one-cycle report of every byte committed by a bus write
//   busy              address-matched transfer in progress, cleared by STOP
module mpu_iic_slave #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_MGMT_RST = 8'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic       upd_we,
  input  logic [6:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  localparam logic [6:0] WHO_AM_I = 7'h75;
  typedef enum logic [2:0] {IDLE, ADDR, REG_PTR, WR_DATA, RD_DATA} state_t;
  state_t state, state_nx;
  logic [7:0] regs [128];
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt;
  logic [7:0] shreg, byte_in, rd_byte;
  logic [6:0] ptr;
  logic       rw, sda_low, rise, fall, start, stop, load_rd;
  // [0],[1] synchronise the pins, [2] keeps the previous synchronised value for edge detection
  always_ff @(posedge clk) begin
    scl_q <= {scl_q[1:0], scl};
    sda_q <= {sda_q[1:0], sda};
  end
  assign rise    = scl_q[1] & ~scl_q[2];
  assign fall    = ~scl_q[1] & scl_q[2];
  assign start   = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop    = scl_q[1] & ~sda_q[2] & sda_q[1];
  assign byte_in = {shreg[6:0], sda_q[1]};
  assign rd_byte = (ptr == WHO_AM_I) ? WHO_AM_I_VAL : regs[ptr];
  // cnt counts scl rising edges within a byte: 1..8 are data bits, 9 is the ACK clock
  assign load_rd = (state == RD_DATA) || (state == ADDR && rw);
  assign sda     = sda_low ? 1'b0 : 1'bz;
  always_comb begin
    state_nx = state;
    if (start) state_nx = ADDR;
    else if (stop) state_nx = IDLE;
    else if (rise && cnt == 4'd7 && state == ADDR && byte_in[7:1] != SLAVE_ADDR) state_nx = IDLE;
    else if (rise && cnt == 4'd8 && state == RD_DATA && sda_q[1]) state_nx = IDLE;
    else if (fall && cnt == 4'd9 && state == ADDR) state_nx = rw ? RD_DATA : REG_PTR;
    else if (fall && cnt == 4'd9 && state == REG_PTR) state_nx = WR_DATA;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_low   <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < 128; i++) regs[7'(i)] <= (i == 'h6B) ? PWR_MGMT_RST : 8'h00;
    end else begin
      state     <= state_nx;
      wr_strobe <= 1'b0;
      if (start) begin
        cnt     <= '0;
        sda_low <= 1'b0;
      end else if (stop) begin
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (state != IDLE && rise) begin
        cnt <= cnt + 4'd1;
        if (state != RD_DATA) shreg <= byte_in;
        if (cnt == 4'd7 && state == ADDR && byte_in[7:1] == SLAVE_ADDR) begin
          busy <= 1'b1;
          rw   <= byte_in[0];
        end
        if (cnt == 4'd7 && state == REG_PTR) ptr <= byte_in[6:0];
        if (cnt == 4'd7 && state == WR_DATA) begin
          wr_strobe <= 1'b1;
          wr_addr   <= ptr;
          wr_data   <= byte_in;
          if (ptr != WHO_AM_I) regs[ptr] <= byte_in;
        end
        if (cnt == 4'd8 && state == RD_DATA) ptr <= ptr + 7'd1;
      end else if (state != IDLE && fall) begin
        if (cnt == 4'd8) sda_low <= (state != RD_DATA);
        else if (cnt == 4'd9) begin
          cnt     <= '0;
          sda_low <= load_rd && !rd_byte[7];
          if (load_rd) shreg <= rd_byte;
          if (state == WR_DATA) ptr <= ptr + 7'd1;
        end else if (state == RD_DATA && cnt != 4'd0) sda_low <= ~shreg[~cnt[2:0]];
      end
      // issued after the bus write so a same-address host update takes precedence
      if (upd_we && upd_addr != WHO_AM_I) regs[upd_addr] <= upd_data;
    end
  end
endmodule

// File: tb/tb_mpu_iic_slave.sv
// tb_mpu_iic_slave: directed bus-level checks of mpu_iic_slave
module tb_mpu_iic_slave;
  localparam int PH = 10;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       upd_we = 1'b0;
  logic [6:0] upd_addr = '0;
  logic [7:0] upd_data = '0;
  logic       wr_strobe, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda;
  int         checks = 0, errors = 0, n_strobe = 0, n_wide = 0;
  logic       prev_strobe = 1'b0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  mpu_iic_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .upd_we(upd_we), .upd_addr(upd_addr), .upd_data(upd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strobe++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (wr_strobe && prev_strobe) n_wide++;
    prev_strobe = wr_strobe;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_low = 1'b0; tick(PH/2); scl = 1'b1; tick(PH); m_low = 1'b1; tick(PH); scl = 1'b0; tick(PH/2);
  endtask
  task automatic i2c_stop;
    m_low = 1'b1; tick(PH/2); scl = 1'b1; tick(PH); m_low = 1'b0; tick(PH);
  endtask
  // coll: fire a host write to 0x00 on exactly the clk the slave commits this bit's byte
  task automatic wr_bit(input logic b, input logic coll);
    m_low = ~b; tick(PH/2); scl = 1'b1;
    if (coll) begin
      tick(2);
      upd_we = 1'b1; upd_addr = 7'h00; upd_data = 8'h99;
      tick(1);
      upd_we = 1'b0;
      check("coll_strobe_same_cycle", wr_strobe, 1);
      tick(PH-3);
    end else tick(PH);
    scl = 1'b0; tick(PH/2);
  endtask
  task automatic rd_bit(output logic b);
    m_low = 1'b0; tick(PH/2); scl = 1'b1; tick(PH/2); b = sda; tick(PH/2); scl = 1'b0; tick(PH/2);
  endtask
  task automatic wr_byte(input logic [7:0] d, input logic coll, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i], coll && i == 0);
    rd_bit(ack);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack, 1'b0);
  endtask
  task automatic wr_reg(input logic [6:0] p, input logic [7:0] d, output logic nak);
    logic a0, a1, a2;
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte({1'b0, p}, 1'b0, a1); wr_byte(d, 1'b0, a2); i2c_stop;
    nak = a0 | a1 | a2;
  endtask
  task automatic rd_reg(input logic [6:0] p, output logic [7:0] d, output logic nak);
    logic a0, a1, a2;
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte({1'b0, p}, 1'b0, a1);
    i2c_start; wr_byte(8'hD1, 1'b0, a2); rd_byte(1'b1, d); i2c_stop;
    nak = a0 | a1 | a2;
  endtask
  initial begin
    logic [7:0] d;
    logic       a0, a1, a2, a3, nak, b;
    int         s0;
    tick(5);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    tick(5);
    rd_reg(7'h6B, d, nak);
    check("pwr_mgmt_reset_val", d, 8'h40);
    check("pwr_mgmt_read_acks", nak, 0);
    s0 = n_strobe;
    i2c_start;
    wr_byte(8'hD0, 1'b0, a0);
    check("busy_after_match", busy, 1);
    wr_byte(8'h6B, 1'b0, a1);
    wr_byte(8'h00, 1'b0, a2);
    i2c_stop;
    check("write_acks", {a0, a1, a2}, 0);
    check("busy_after_stop", busy, 0);
    check("write_strobes", n_strobe - s0, 1);
    check("write_addr", last_addr, 7'h6B);
    check("write_data", last_data, 8'h00);
    rd_reg(7'h6B, d, nak);
    check("readback_6b", d, 8'h00);
    for (int i = 0; i < 14; i++) begin
      upd_we = 1'b1; upd_addr = 7'(59 + i); upd_data = 8'(i + 1);
      tick(1);
    end
    upd_addr = 7'h49; upd_data = 8'hA5;
    tick(1);
    upd_we = 1'b0;
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte(8'h3B, 1'b0, a1);
    i2c_start; wr_byte(8'hD1, 1'b0, a2);
    for (int i = 0; i < 14; i++) begin
      rd_byte(i == 13, d);
      check($sformatf("burst_byte%0d", i), d, 32'(i + 1));
    end
    i2c_stop;
    check("burst_acks", {a0, a1, a2}, 0);
    check("burst_busy_after_stop", busy, 0);
    i2c_start; wr_byte(8'hD1, 1'b0, a0); rd_byte(1'b1, d); i2c_stop;
    check("ptr_after_burst", d, 8'hA5);
    check("ptr_read_ack", a0, 0);
    s0 = n_strobe;
    wr_reg(7'h75, 8'h55, nak);
    check("whoami_write_acks", nak, 0);
    check("whoami_strobes", n_strobe - s0, 1);
    check("whoami_wr_addr", last_addr, 7'h75);
    check("whoami_wr_data", last_data, 8'h55);
    rd_reg(7'h75, d, nak);
    check("whoami_read", d, 8'h68);
    s0 = n_strobe;
    i2c_start;
    wr_byte(8'hA0, 1'b0, a0);
    check("bad_addr_nack", a0, 1);
    check("bad_addr_busy", busy, 0);
    wr_byte(8'h6B, 1'b0, a1);
    wr_byte(8'h12, 1'b0, a2);
    i2c_stop;
    check("bad_addr_bytes_ignored", {a1, a2}, 2'b11);
    check("bad_addr_strobes", n_strobe - s0, 0);
    s0 = n_strobe;
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte(8'h7F, 1'b0, a1);
    wr_byte(8'hC3, 1'b0, a2); wr_byte(8'h3C, 1'b0, a3); i2c_stop;
    check("wrap_acks", {a0, a1, a2, a3}, 0);
    check("wrap_strobes", n_strobe - s0, 2);
    check("wrap_last_addr", last_addr, 7'h00);
    check("wrap_last_data", last_data, 8'h3C);
    rd_reg(7'h7F, d, nak);
    check("wrap_reg_7f", d, 8'hC3);
    rd_reg(7'h00, d, nak);
    check("wrap_reg_00", d, 8'h3C);
    s0 = n_strobe;
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte(8'h00, 1'b0, a1); wr_byte(8'h11, 1'b1, a2); i2c_stop;
    check("coll_strobes", n_strobe - s0, 1);
    check("coll_wr_data", last_data, 8'h11);
    rd_reg(7'h00, d, nak);
    check("coll_host_wins", d, 8'h99);
    i2c_start; wr_byte(8'hD0, 1'b0, a0); wr_byte(8'h6B, 1'b0, a1);
    i2c_start; wr_byte(8'hD1, 1'b0, a2);
    for (int i = 0; i < 3; i++) rd_bit(b);
    check("midread_sda_driven", sda, 0);
    rst_n = 1'b0;
    upd_we = 1'b1; upd_addr = 7'h20; upd_data = 8'h77;
    tick(1);
    check("midread_sda_released", sda, 1);
    check("midread_busy_cleared", busy, 0);
    tick(3);
    upd_we = 1'b0;
    rst_n = 1'b1;
    tick(2);
    i2c_stop;
    rd_reg(7'h6B, d, nak);
    check("post_rst_6b", d, 8'h40);
    check("post_rst_acks", nak, 0);
    rd_reg(7'h00, d, nak);
    check("post_rst_00", d, 8'h00);
    rd_reg(7'h20, d, nak);
    check("upd_ignored_in_rst", d, 8'h00);
    check("strobe_width", n_wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
